// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, PS/2 prefix codes and filter width helper for the scancode receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  function automatic int filt_cnt_w(input int len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction
endpackage

// File: rtl/ps2_scancode_rx_filter.sv
// ps2_line_filter: synchronises the PS/2 lines, deglitches ps2_clk and flags its filtered falling edges
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);
  localparam int CW = filt_cnt_w(FILTER_LEN);
  logic [1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, fall_q, fall_d, diff, hit;
  assign diff = clk_sync_q[1] ^ lvl_q;
  assign hit = diff && (cnt_q == CW'(FILTER_LEN - 1));
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    cnt_d = (diff && !hit) ? cnt_q + 1'b1 : '0;
    lvl_d = hit ? ~lvl_q : lvl_q;
    fall_d = hit & lvl_q;
  end
  // Lines idle high, so the synchronisers and filter come out of reset at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      data_sync_q <= 2'b11;
      cnt_q <= '0;
      lvl_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      data_sync_q <= data_sync_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      fall_q <= fall_d;
    end
  end
  assign fall = fall_q;
  assign data_s = data_sync_q[1];
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 device-to-host frame receiver that checks framing, drops break
// and extended-prefix bytes, and presents accepted make codes with a one-cycle strobe
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d, scancode_q, scancode_d;
  logic [TW-1:0] timer_q, timer_d;
  logic parity_q, parity_d, brk_q, brk_d, valid_q, valid_d;
  logic perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;
  logic fall, data_s, timeout, good;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .fall    (fall),
    .data_s  (data_s)
  );
  // Timer holds the cycles since the last fall; the abort beats a coincident fall
  assign timeout = (state_q != IDLE) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign good = (^shift_q ^ parity_q) && data_s;
  always_comb begin
    state_d = state_q;
    bitcnt_d = bitcnt_q;
    shift_d = shift_q;
    parity_d = parity_q;
    brk_d = brk_q;
    scancode_d = scancode_q;
    valid_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    timer_d = (fall || state_q == IDLE) ? '0 : timer_q + 1'b1;
    if (timeout) begin
      state_d = IDLE;
      ferr_d = 1'b1;
      brk_d = 1'b0;
      timer_d = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = data_s ? IDLE : DATA;
          bitcnt_d = '0;
        end
        DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          state_d = (bitcnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          parity_d = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!good) begin
            perr_d = 1'b1;
            brk_d = 1'b0;
          end else if (shift_q == PS2_BREAK) begin
            brk_d = 1'b1;
          end else if (shift_q != PS2_EXT) begin
            brk_d = 1'b0;
            valid_d = !brk_q;
            scancode_d = brk_q ? scancode_q : shift_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bitcnt_q <= '0;
      shift_q <= '0;
      parity_q <= 1'b0;
      brk_q <= 1'b0;
      scancode_q <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q <= shift_d;
      parity_q <= parity_d;
      brk_q <= brk_d;
      scancode_q <= scancode_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      busy_q <= busy_d;
    end
  end
  assign scancode = scancode_q;
  assign scancode_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err = ferr_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed PS/2 frames against a frame-level reference model of the receiver
module tb_ps2_scancode_rx;
  localparam int FL = 8;
  localparam int TO = 400;
  localparam int H = 40;
  logic clk = 0, rst_n = 0, ps2_clk = 1, ps2_data = 1;
  logic [7:0] scancode;
  logic scancode_valid, parity_err, frame_err, busy;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int nv = 0, np = 0, nf = 0, tv = 0, tf = 0, fall_drv = 0;
  int v0, p0, f0;

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: raw line history, window filter, bit list per frame
  logic hc[$], hd[$];
  logic ml = 1, mbrk = 0;
  logic [10:0] mfr = '0;
  logic [7:0] b8;
  int nb = 0, age = 0;
  logic [7:0] e_sc = 0, n_sc = 0;
  logic e_v = 0, e_p = 0, e_f = 0, e_b = 0, n_v = 0, n_p = 0, n_f = 0, n_b = 0;
  logic hit, fl, d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc = {};
      hd = {};
      for (int i = 0; i < FL + 2; i++) begin
        hc.push_back(1'b1);
        hd.push_back(1'b1);
      end
      ml = 1; mbrk = 0; nb = 0; age = 0;
      e_sc = 0; n_sc = 0;
      {e_v, e_p, e_f, e_b, n_v, n_p, n_f, n_b} = '0;
    end else begin
      {e_sc, e_v, e_p, e_f, e_b} = {n_sc, n_v, n_p, n_f, n_b};
      hc.push_front(ps2_clk); void'(hc.pop_back());
      hd.push_front(ps2_data); void'(hd.pop_back());
      hit = 1;
      for (int i = 2; i < FL + 2; i++) if (hc[i] == ml) hit = 0;
      fl = 0;
      if (hit) begin
        ml = ~ml;
        fl = !ml;
      end
      d = hd[1];
      {n_v, n_p, n_f} = '0;
      age++;
      if (nb > 0 && age == TO) begin
        nb = 0; n_f = 1; mbrk = 0;
      end else if (fl) begin
        age = 0;
        if (nb > 0 || !d) begin
          mfr[nb] = d;
          nb++;
        end
        if (nb == 11) begin
          nb = 0;
          b8 = mfr[8:1];
          if (!(^mfr[9:1]) || !mfr[10]) begin
            n_p = 1; mbrk = 0;
          end else if (b8 == 8'hF0) mbrk = 1;
          else if (b8 != 8'hE0) begin
            if (mbrk) mbrk = 0;
            else begin
              n_sc = b8; n_v = 1;
            end
          end
        end
      end
      n_b = (nb > 0);
    end
  end

  always @(negedge clk) begin
    n_chk++;
    if ({scancode, scancode_valid, parity_err, frame_err, busy} !== {e_sc, e_v, e_p, e_f, e_b}) begin
      n_fail++;
      $display("FAIL model cyc=%0d got sc=%h v=%b pe=%b fe=%b busy=%b want sc=%h v=%b pe=%b fe=%b busy=%b",
               cyc, scancode, scancode_valid, parity_err, frame_err, busy, e_sc, e_v, e_p, e_f, e_b);
    end
    if (scancode_valid === 1'b1) begin nv++; tv = cyc; end
    if (parity_err === 1'b1) np++;
    if (frame_err === 1'b1) begin nf++; tf = cyc; end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] fr_of(input logic [7:0] b, input bit bad_par, input bit stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send(input logic [10:0] f, input int lo, input int hi, input bit glitch);
    for (int i = lo; i < hi; i++) begin
      ps2_data = f[i];
      if (glitch && i == 4) begin
        tick(15); ps2_clk = 0; tick(FL - 1); ps2_clk = 1; tick(H - 15 - (FL - 1));
      end else tick(H);
      ps2_clk = 0;
      fall_drv = cyc;
      tick(H);
      ps2_clk = 1;
    end
    ps2_data = 1;
  endtask

  task automatic frame(input logic [7:0] b);
    send(fr_of(b, 0, 1), 0, 11, 0);
    tick(2 * H);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("rst_scancode", int'(scancode), 0);
    chk("rst_strobes", int'({scancode_valid, parity_err, frame_err, busy}), 0);
    rst_n = 1;
    tick(5);

    v0 = nv;
    send(fr_of(8'h16, 0, 1), 0, 3, 0);
    chk("busy_mid_frame", int'(busy), 1);
    send(fr_of(8'h16, 0, 1), 3, 11, 0);
    tick(FL + 6);
    chk("m16_valid_count", nv - v0, 1);
    chk("m16_latency", tv, fall_drv + FL + 3);
    chk("m16_scancode", int'(scancode), 8'h16);
    chk("m16_model_sc", int'(e_sc), 8'h16);
    chk("m16_busy_after", int'(busy), 0);
    tick(2 * H);

    frame(8'h1E);
    v0 = nv;
    frame(8'hF0);
    frame(8'h16);
    chk("break_no_valid", nv - v0, 0);
    chk("break_sc_held", int'(scancode), 8'h1E);
    frame(8'h26);
    chk("after_break_valid", nv - v0, 1);
    chk("after_break_sc", int'(scancode), 8'h26);

    v0 = nv; p0 = np;
    send(fr_of(8'h1E, 1, 1), 0, 11, 0); tick(2 * H);
    chk("bad_par_perr", np - p0, 1);
    send(fr_of(8'h1E, 0, 0), 0, 11, 0); tick(2 * H);
    chk("bad_stop_perr", np - p0, 2);
    chk("bad_no_valid", nv - v0, 0);
    chk("bad_sc_held", int'(scancode), 8'h26);

    f0 = nf;
    send(fr_of(8'h4D, 0, 1), 0, 6, 0);
    tick(TO + FL + 10);
    chk("timeout_ferr", nf - f0, 1);
    chk("timeout_time", tf, fall_drv + FL + TO + 3);
    chk("timeout_idle", int'(busy), 0);
    v0 = nv;
    frame(8'h4D);
    chk("post_to_valid", nv - v0, 1);
    chk("post_to_sc", int'(scancode), 8'h4D);

    v0 = nv;
    frame(8'hE0);
    frame(8'h4D);
    chk("ext_single_valid", nv - v0, 1);
    chk("ext_sc", int'(scancode), 8'h4D);
    v0 = nv; p0 = np;
    send(fr_of(8'h1C, 0, 1), 0, 11, 1); tick(2 * H);
    chk("glitch_valid", nv - v0, 1);
    chk("glitch_no_perr", np - p0, 0);
    chk("glitch_sc", int'(scancode), 8'h1C);

    send(fr_of(8'h32, 0, 1), 0, 5, 0);
    tick(10);
    #2 rst_n = 0;
    #1;
    chk("async_rst_sc", int'(scancode), 0);
    chk("async_rst_flags", int'({scancode_valid, parity_err, frame_err, busy}), 0);
    tick(3);
    rst_n = 1;
    tick(5);
    v0 = nv;
    frame(8'h31);
    chk("post_rst_valid", nv - v0, 1);
    chk("post_rst_sc", int'(scancode), 8'h31);

    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
